// File: rtl/fetch_unit.sv
// fetch_unit: sequential PC generation, imem request issue, prefetch FIFO and redirect flush; FETCH_PERF_EN adds perf counters
module fetch_unit #(
    parameter int XLEN = 16,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_pc,
    output logic [XLEN-1:0] dec_instr
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_stall_cycles,
    output logic [15:0]     perf_dropped
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    logic [XLEN-1:0] fetch_pc, rsp_pc, target_pc;
    logic [CW-1:0] outstanding, drop_cnt, fifo_count;
    logic [CW:0] credits;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [XLEN-1:0] pc_mem [FIFO_DEPTH];
    logic [XLEN-1:0] instr_mem [FIFO_DEPTH];
    logic req_fire, drop, push, pop;
    assign target_pc = redirect_pc & ~XLEN'(1);
    assign credits = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem_req_valid = !rst && !redirect_valid && (credits < (CW + 1)'(FIFO_DEPTH));
    assign imem_req_addr = fetch_pc;
    assign req_fire = imem_req_valid && imem_req_ready;
    assign drop = imem_rsp_valid && (redirect_valid || drop_cnt != '0);
    assign push = imem_rsp_valid && !drop;
    assign dec_valid = !rst && !redirect_valid && fifo_count != '0;
    assign pop = dec_valid && dec_ready;
    assign dec_pc = pc_mem[rd_ptr];
    assign dec_instr = instr_mem[rd_ptr];
    // fetch PC, credit/drop accounting and prefetch FIFO; rsp_pc tracks the PC of the next kept response
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            rsp_pc <= RESET_PC;
            outstanding <= '0;
            drop_cnt <= '0;
            fifo_count <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_mem[i] <= '0;
                instr_mem[i] <= '0;
            end
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                fetch_pc <= target_pc;
                rsp_pc <= target_pc;
                drop_cnt <= outstanding - CW'(imem_rsp_valid);
                fifo_count <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + XLEN'(2);
                if (drop) drop_cnt <= drop_cnt - CW'(1);
                if (push) begin
                    pc_mem[wr_ptr] <= rsp_pc;
                    instr_mem[wr_ptr] <= imem_rsp_data;
                    wr_ptr <= wr_ptr + AW'(1);
                    rsp_pc <= rsp_pc + XLEN'(2);
                end
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                fifo_count <= fifo_count + CW'(push) - CW'(pop);
            end
        end
    end
    // simulation invariants on credit, drop and response accounting
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (credits <= (CW + 1)'(FIFO_DEPTH));
            assert (drop_cnt <= outstanding);
            assert (!(imem_rsp_valid && outstanding == '0));
        end
    end
`ifdef FETCH_PERF_EN
    // saturating stall and discarded-response counters
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_dropped <= '0;
        end else begin
            if (dec_ready && !dec_valid && perf_stall_cycles != '1) perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (drop && perf_dropped != '1) perf_dropped <= perf_dropped + 16'd1;
        end
    end
`endif
endmodule
